// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : regfile_pkg
//  Purpose    : Shared constants and helpers for the multi-port register file.
//               - NREGS_I / NREGS_E : register counts for RV32I / RV32E.
//               - aw_of()           : select width for a given register count.
//               - params_legal()    : elaboration-time parameter sanity check.
//  Revision   : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int NREGS_I = 32;
  localparam int NREGS_E = 16;

  // Register select width; register counts are powers of two, so every
  // select value addresses a real register.
  function automatic int aw_of(input int nregs);
    return $clog2(nregs);
  endfunction

  // True when the register count, read-port count and write-port count are
  // all in the supported set.
  function automatic bit params_legal(input int nregs, input int nrd, input int nwr);
    return ((nregs == NREGS_I) || (nregs == NREGS_E)) &&
           (nrd >= 1) && (nrd <= 4) &&
           (nwr >= 1) && (nwr <= 2);
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Interface  : regfile_mp_if
//  Purpose    : Bundles the register-file access signals between the core
//               (master) and the register file (slave).
//  Signals    : clk_enable            core running (1) / halted (0)
//               r_sel / r_data / r_busy    NRD read ports (flat, port k at k*W)
//               w_en / w_sel / w_data      NWR writeback ports
//               iss_en / iss_sel           destination of a newly issued instr
//               dbg_reg_sel / dbg_reg_data / dbg_w_en / dbg_w_data  debug port
//  Modports   : master (core side), slave (register file side)
//  Revision   : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) ();
  import regfile_pkg::*;

  localparam int AW = aw_of(NREGS);

  logic                 clk_enable;
  logic [NRD*AW-1:0]    r_sel;
  logic [NRD*XLEN-1:0]  r_data;
  logic [NRD-1:0]       r_busy;
  logic [NWR-1:0]       w_en;
  logic [NWR*AW-1:0]    w_sel;
  logic [NWR*XLEN-1:0]  w_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_sel;
  logic [AW-1:0]        dbg_reg_sel;
  logic [XLEN-1:0]      dbg_reg_data;
  logic                 dbg_w_en;
  logic [XLEN-1:0]      dbg_w_data;

  modport master (
    output clk_enable, r_sel, w_en, w_sel, w_data, iss_en, iss_sel,
           dbg_reg_sel, dbg_w_en, dbg_w_data,
    input  r_data, r_busy, dbg_reg_data
  );

  modport slave (
    input  clk_enable, r_sel, w_en, w_sel, w_data, iss_en, iss_sel,
           dbg_reg_sel, dbg_w_en, dbg_w_data,
    output r_data, r_busy, dbg_reg_data
  );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module     : regfile_scoreboard
//  Purpose    : Per-register busy (pending write) bits.
//               Running : writebacks clear, an issue sets; issue beats a
//                         same-cycle writeback to the same register.
//               Halted  : only a debug write can clear a bit.
//               Bit 0 (x0) is never set.
//  Ports      : clk, rst_n (sync, active-low)
//               i_clk_enable, i_w_en/i_w_sel, i_iss_en/i_iss_sel,
//               i_dbg_w_en/i_dbg_reg_sel  -> o_busy[NREGS-1:0]
//  Revision   : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  parameter int AW    = aw_of(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clk_enable,
  input  logic [NWR-1:0]    i_w_en,
  input  logic [NWR*AW-1:0] i_w_sel,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_sel,
  input  logic              i_dbg_w_en,
  input  logic [AW-1:0]     i_dbg_reg_sel,
  output logic [NREGS-1:0]  o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clk_enable) begin
      for (int p = 0; p < NWR; p++) begin
        if (i_w_en[p]) begin
          w_busy_nxt[i_w_sel[p*AW +: AW]] = 1'b0;
        end
      end
      // Applied after the clears so a new producer keeps the register busy.
      if (i_iss_en) begin
        w_busy_nxt[i_iss_sel] = 1'b1;
      end
    end else if (i_dbg_w_en) begin
      w_busy_nxt[i_dbg_reg_sel] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module     : regfile_mp
//  Purpose    : Multi-port integer register file (RV32I/RV32E) with busy
//               scoreboard, optional write-to-read bypass and a debug write
//               port that is only active while the core is halted.
//  Ports      : clk         clock
//               rst_n       synchronous active-low reset (clears data + busy)
//               bus         regfile_mp_if.slave (read/write/issue/debug)
//  Timing     : With BYPASS=1 there is a combinational path
//               w_en/w_sel/w_data -> r_data and w_en/w_sel/iss_* -> r_busy,
//               through a select compare and an NWR:1 mux per read port.
//               Treat it as a same-cycle path from the writeback stage
//               flops to the decode-stage operand flops.
//  Revision   : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam int AW = aw_of(NREGS);

  if (params_legal(NREGS, NRD, NWR) == 1'b0) begin : g_param_check
    $error("regfile_mp: unsupported NREGS/NRD/NWR combination");
  end

  logic [XLEN-1:0]  w_regs [NREGS];
  logic [NREGS-1:0] w_busy;

  // --------------------------------------------------------------------------
  // Storage: one flop row per register; x0 is a constant zero.
  // Later write ports override earlier ones, so port 1 wins a collision.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign w_regs[i] = '0;
    end else begin : g_store
      logic [XLEN-1:0] r_q;
      logic            w_we;
      logic [XLEN-1:0] w_wd;

      always_comb begin
        w_we = 1'b0;
        w_wd = '0;
        if (bus.clk_enable) begin
          for (int p = 0; p < NWR; p++) begin
            if (bus.w_en[p] && (bus.w_sel[p*AW +: AW] == AW'(i))) begin
              w_we = 1'b1;
              w_wd = bus.w_data[p*XLEN +: XLEN];
            end
          end
        end else if (bus.dbg_w_en && (bus.dbg_reg_sel == AW'(i))) begin
          w_we = 1'b1;
          w_wd = bus.dbg_w_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_we) begin
          r_q <= w_wd;
        end
      end

      assign w_regs[i] = r_q;
    end
  end

  // --------------------------------------------------------------------------
  // Busy scoreboard
  // --------------------------------------------------------------------------
  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clk_enable  (bus.clk_enable),
    .i_w_en        (bus.w_en),
    .i_w_sel       (bus.w_sel),
    .i_iss_en      (bus.iss_en),
    .i_iss_sel     (bus.iss_sel),
    .i_dbg_w_en    (bus.dbg_w_en),
    .i_dbg_reg_sel (bus.dbg_reg_sel),
    .o_busy        (w_busy)
  );

  // --------------------------------------------------------------------------
  // Read ports with optional forwarding of the current cycle's writeback.
  // A forwarded register is no longer pending unless the same cycle issues
  // a new producer for it.
  // --------------------------------------------------------------------------
  logic [AW-1:0]   w_rsel [NRD];
  logic [NRD-1:0]  w_rhit;

  always_comb begin
    bus.r_data = '0;
    bus.r_busy = '0;
    w_rhit     = '0;
    for (int k = 0; k < NRD; k++) begin
      w_rsel[k] = bus.r_sel[k*AW +: AW];
      bus.r_data[k*XLEN +: XLEN] = w_regs[w_rsel[k]];
      bus.r_busy[k]              = w_busy[w_rsel[k]];
      if ((BYPASS != 0) && bus.clk_enable && (w_rsel[k] != '0)) begin
        for (int p = 0; p < NWR; p++) begin
          if (bus.w_en[p] && (bus.w_sel[p*AW +: AW] == w_rsel[k])) begin
            w_rhit[k]                  = 1'b1;
            bus.r_data[k*XLEN +: XLEN] = bus.w_data[p*XLEN +: XLEN];
          end
        end
        if (w_rhit[k]) begin
          bus.r_busy[k] = bus.iss_en && (bus.iss_sel == w_rsel[k]);
        end
      end
    end
  end

  // Debug view is the raw stored array, never the forwarded value.
  assign bus.dbg_reg_data = w_regs[bus.dbg_reg_sel];

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module     : tb_regfile_mp
//  Purpose    : Directed self-checking bench for regfile_mp. Three instances:
//               dut_a  RV32I, 2 read, 2 write, bypass on
//               dut_b  RV32I, 2 read, 1 write, bypass off
//               dut_c  RV32E, 3 read, 1 write, bypass on
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) ifb ();
  regfile_mp_if #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1)) ifc ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.clk_enable = 1'b1; ifa.w_en = '0; ifa.iss_en = 1'b0; ifa.dbg_w_en = 1'b0;
    ifb.clk_enable = 1'b1; ifb.w_en = '0; ifb.iss_en = 1'b0; ifb.dbg_w_en = 1'b0;
    ifc.clk_enable = 1'b1; ifc.w_en = '0; ifc.iss_en = 1'b0; ifc.dbg_w_en = 1'b0;
  endtask

  initial begin
    // ---------------- reset with active traffic ----------------
    ifa.r_sel = '0; ifa.w_sel = '0; ifa.w_data = '0; ifa.iss_sel = '0;
    ifa.dbg_reg_sel = '0; ifa.dbg_w_data = '0;
    ifb.r_sel = '0; ifb.w_sel = '0; ifb.w_data = '0; ifb.iss_sel = '0;
    ifb.dbg_reg_sel = '0; ifb.dbg_w_data = '0;
    ifc.r_sel = '0; ifc.w_sel = '0; ifc.w_data = '0; ifc.iss_sel = '0;
    ifc.dbg_reg_sel = '0; ifc.dbg_w_data = '0;
    idle();
    rst_n = 1'b0;
    ifa.w_en = 2'b11; ifa.w_sel = {5'd6, 5'd5}; ifa.w_data = {32'h2, 32'h1};
    ifa.iss_en = 1'b1; ifa.iss_sel = 5'd5;
    ifb.w_en = 1'b1; ifb.w_sel = 5'd5; ifb.w_data = 32'h3;
    ifc.w_en = 1'b1; ifc.w_sel = 4'd5; ifc.w_data = 32'h4;
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ifa.r_sel = {5'd0, 5'(i)};
      ifa.dbg_reg_sel = 5'(i);
      #1;
      chk("rst_rdata", ifa.r_data[31:0], 32'h0);
      chk("rst_rbusy", 32'(ifa.r_busy[0]), 32'h0);
      chk("rst_dbg", ifa.dbg_reg_data, 32'h0);
    end
    ifb.r_sel = {5'd0, 5'd5}; ifc.r_sel = {4'd0, 4'd0, 4'd5};
    #1;
    chk("rst_b_x5", ifb.r_data[31:0], 32'h0);
    chk("rst_c_x5", ifc.r_data[31:0], 32'h0);

    // ---------------- write x5, bypass vs no bypass ----------------
    ifa.w_en = 2'b01; ifa.w_sel = {5'd0, 5'd5}; ifa.w_data = {32'h0, 32'hDEADBEEF};
    ifa.r_sel = {5'd0, 5'd5};
    ifb.w_en = 1'b1; ifb.w_sel = 5'd5; ifb.w_data = 32'hDEADBEEF;
    #1;
    chk("byp_same_cycle", ifa.r_data[31:0], 32'hDEADBEEF);
    chk("nobyp_same_cycle", ifb.r_data[31:0], 32'h0);
    tick(); idle(); #1;
    chk("byp_next_cycle", ifa.r_data[31:0], 32'hDEADBEEF);
    chk("nobyp_next_cycle", ifb.r_data[31:0], 32'hDEADBEEF);

    // ---------------- dual write collision on x7 ----------------
    ifa.w_en = 2'b11; ifa.w_sel = {5'd7, 5'd7}; ifa.w_data = {32'h22, 32'h11};
    ifa.r_sel = {5'd0, 5'd7};
    #1;
    chk("dual_byp_prio", ifa.r_data[31:0], 32'h22);
    tick(); idle(); #1;
    chk("dual_stored_prio", ifa.r_data[31:0], 32'h22);

    // ---------------- writes to x0 ----------------
    ifa.w_en = 2'b11; ifa.w_sel = {5'd0, 5'd0}; ifa.w_data = {32'hFFFFFFFF, 32'hEEEEEEEE};
    ifa.r_sel = {5'd0, 5'd0};
    #1;
    chk("x0_byp", ifa.r_data[63:32], 32'h0);
    tick(); idle(); #1;
    chk("x0_stored", ifa.r_data[31:0], 32'h0);

    // ---------------- two ports, two registers ----------------
    ifa.w_en = 2'b11; ifa.w_sel = {5'd9, 5'd8}; ifa.w_data = {32'h44, 32'h33};
    tick(); idle();
    ifa.r_sel = {5'd9, 5'd8};
    #1;
    chk("dual_x8", ifa.r_data[31:0], 32'h33);
    chk("dual_x9", ifa.r_data[63:32], 32'h44);

    // ---------------- scoreboard ----------------
    ifa.iss_en = 1'b1; ifa.iss_sel = 5'd9; ifa.r_sel = {5'd0, 5'd9};
    #1;
    chk("iss_busy_same_cycle", 32'(ifa.r_busy[0]), 32'h0);
    tick(); idle(); #1;
    chk("iss_busy_next", 32'(ifa.r_busy[0]), 32'h1);
    ifa.w_en = 2'b01; ifa.w_sel = {5'd0, 5'd9}; ifa.w_data = {32'h0, 32'h99};
    ifa.iss_en = 1'b1; ifa.iss_sel = 5'd9;
    #1;
    chk("wb_iss_byp_busy", 32'(ifa.r_busy[0]), 32'h1);
    chk("wb_iss_byp_data", ifa.r_data[31:0], 32'h99);
    tick(); idle(); #1;
    chk("wb_iss_busy_kept", 32'(ifa.r_busy[0]), 32'h1);
    ifa.w_en = 2'b01; ifa.w_sel = {5'd0, 5'd9}; ifa.w_data = {32'h0, 32'hAA};
    #1;
    chk("wb_only_byp_busy", 32'(ifa.r_busy[0]), 32'h0);
    chk("wb_only_byp_data", ifa.r_data[31:0], 32'hAA);
    tick(); idle(); #1;
    chk("wb_only_busy", 32'(ifa.r_busy[0]), 32'h0);
    chk("wb_only_data", ifa.r_data[31:0], 32'hAA);

    // no-bypass instance: busy is stored state only
    ifb.iss_en = 1'b1; ifb.iss_sel = 5'd4;
    tick(); idle();
    ifb.r_sel = {5'd0, 5'd4};
    #1;
    chk("b_iss_busy", 32'(ifb.r_busy[0]), 32'h1);
    ifb.w_en = 1'b1; ifb.w_sel = 5'd4; ifb.w_data = 32'h4444;
    #1;
    chk("b_wb_busy_same", 32'(ifb.r_busy[0]), 32'h1);
    chk("b_wb_data_same", ifb.r_data[31:0], 32'h0);
    tick(); idle(); #1;
    chk("b_wb_busy_next", 32'(ifb.r_busy[0]), 32'h0);
    chk("b_wb_data_next", ifb.r_data[31:0], 32'h4444);

    // ---------------- halt ----------------
    ifa.iss_en = 1'b1; ifa.iss_sel = 5'd3;
    tick(); idle();
    ifa.r_sel = {5'd3, 5'd5};
    #1;
    chk("x3_busy_set", 32'(ifa.r_busy[1]), 32'h1);
    ifa.clk_enable = 1'b0;
    ifa.w_en = 2'b01; ifa.w_sel = {5'd0, 5'd5}; ifa.w_data = {32'h0, 32'h55};
    ifa.iss_en = 1'b1; ifa.iss_sel = 5'd6;
    #1;
    chk("halt_no_byp", ifa.r_data[31:0], 32'hDEADBEEF);
    tick(); idle();
    ifa.r_sel = {5'd6, 5'd5};
    #1;
    chk("halt_no_write", ifa.r_data[31:0], 32'hDEADBEEF);
    chk("halt_no_issue", 32'(ifa.r_busy[1]), 32'h0);

    ifa.clk_enable = 1'b0;
    ifa.dbg_w_en = 1'b1; ifa.dbg_reg_sel = 5'd3; ifa.dbg_w_data = 32'h1234;
    tick();
    ifa.dbg_w_en = 1'b0;
    ifa.r_sel = {5'd3, 5'd5};
    #1;
    chk("dbg_write", ifa.dbg_reg_data, 32'h1234);
    chk("dbg_clears_busy", 32'(ifa.r_busy[1]), 32'h0);
    chk("dbg_read_port", ifa.r_data[63:32], 32'h1234);

    ifa.clk_enable = 1'b1;
    ifa.dbg_w_en = 1'b1; ifa.dbg_reg_sel = 5'd3; ifa.dbg_w_data = 32'h5678;
    tick(); idle(); #1;
    chk("dbg_ignored_running", ifa.dbg_reg_data, 32'h1234);

    ifa.clk_enable = 1'b0;
    ifa.dbg_w_en = 1'b1; ifa.dbg_reg_sel = 5'd0; ifa.dbg_w_data = 32'hFFFF;
    tick(); idle(); #1;
    chk("dbg_x0_ignored", ifa.dbg_reg_data, 32'h0);

    // ---------------- RV32E, three read ports ----------------
    ifc.w_en = 1'b1; ifc.w_sel = 4'd15; ifc.w_data = 32'hA5A5A5A5;
    ifc.r_sel = {4'd15, 4'd15, 4'd15};
    #1;
    chk("e_byp_p0", ifc.r_data[31:0], 32'hA5A5A5A5);
    chk("e_byp_p2", ifc.r_data[95:64], 32'hA5A5A5A5);
    tick(); idle(); #1;
    chk("e_p0", ifc.r_data[31:0], 32'hA5A5A5A5);
    chk("e_p1", ifc.r_data[63:32], 32'hA5A5A5A5);
    chk("e_p2", ifc.r_data[95:64], 32'hA5A5A5A5);
    chk("e_busy", 32'(ifc.r_busy), 32'h0);

    // ---------------- reset mid-operation ----------------
    ifa.r_sel = {5'd10, 5'd5};
    ifa.w_en = 2'b01; ifa.w_sel = {5'd0, 5'd10}; ifa.w_data = {32'h0, 32'hABCD};
    ifa.iss_en = 1'b1; ifa.iss_sel = 5'd11;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("midrst_x10", ifa.r_data[31:0], 32'h0);
    chk("midrst_x5", ifa.r_data[63:32], 32'h0);
    ifa.r_sel = {5'd11, 5'd7};
    #1;
    chk("midrst_x7", ifa.r_data[31:0], 32'h0);
    chk("midrst_busy11", 32'(ifa.r_busy[1]), 32'h0);
    ifc.r_sel = {4'd0, 4'd0, 4'd15};
    #1;
    chk("midrst_e_x15", ifc.r_data[31:0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire
